// File: rtl/bus_master.sv
// Asynchronous 68000-style bus master: runs one read or write cycle per
// request through ADDR -> STROBE -> END -> RECOVER, aborting on a bus error,
// a timeout or a misaligned word access.
module bus_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic        REQ_SIZE,
    input  logic [23:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [23:0] ADDR_OUT,
    output logic        AS,
    output logic        UDS,
    output logic        LDS,
    output logic        RW,
    output logic [15:0] DATA_OUT,
    output logic        DATA_OE,
    input  logic [15:0] DATA_IN,
    input  logic        DTACK,
    input  logic        BERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_END,
        ST_RECOVER
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        as_q, as_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Next-state logic; strobes, DONE and ERR are computed from the next state
    // so that every bus-visible control comes straight out of a flop.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        size_d  = size_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        as_d    = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    if (!REQ_SIZE && REQ_ADDR[0]) begin
                        // Misaligned word: abort without touching the bus.
                        state_d = ST_END;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        addr_d  = REQ_ADDR;
                        rw_d    = REQ_RW;
                        size_d  = REQ_SIZE;
                        if (!REQ_RW) begin
                            dout_d = REQ_SIZE ? {REQ_WDATA[7:0], REQ_WDATA[7:0]} : REQ_WDATA;
                            oe_d   = 1'b1;
                        end
                    end
                end
            end
            ST_ADDR: begin
                state_d = ST_STROBE;
                cnt_d   = 8'd0;
                as_d    = 1'b0;
                // Word uses both lanes; an even byte is the upper lane, an odd byte the lower.
                uds_d   = size_q & addr_q[0];
                lds_d   = size_q & ~addr_q[0];
            end
            ST_STROBE: begin
                if (!BERR) begin
                    state_d = ST_END;
                    err_d   = 1'b1;
                end else if (!DTACK) begin
                    state_d = ST_END;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        if (!size_q)
                            rdata_d = DATA_IN;
                        else if (!addr_q[0])
                            rdata_d = {8'h00, DATA_IN[15:8]};
                        else
                            rdata_d = {8'h00, DATA_IN[7:0]};
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    state_d = ST_END;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    as_d  = 1'b0;
                    uds_d = uds_q;
                    lds_d = lds_q;
                end
            end
            ST_END: begin
                state_d = ST_RECOVER;
                rw_d    = 1'b1;
                oe_d    = 1'b0;
            end
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously so a reset mid-cycle
    // releases the bus without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= 24'd0;
            rw_q    <= 1'b1;
            size_q  <= 1'b0;
            dout_q  <= 16'd0;
            oe_q    <= 1'b0;
            as_q    <= 1'b1;
            uds_q   <= 1'b1;
            lds_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 16'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            as_q    <= as_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign RDATA    = rdata_q;
    assign ADDR_OUT = addr_q;
    assign AS       = as_q;
    assign UDS      = uds_q;
    assign LDS      = lds_q;
    assign RW       = rw_q;
    assign DATA_OUT = dout_q;
    assign DATA_OE  = oe_q;

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: a table of transactions driven through a bus
// responder, with DONE/ERR/RDATA checked against a scoreboard queue, plus
// reset and mid-cycle reset sequences.
module tb_bus_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ = 1'b0;
    logic        REQ_RW = 1'b1;
    logic        REQ_SIZE = 1'b0;
    logic [23:0] REQ_ADDR = 24'd0;
    logic [15:0] REQ_WDATA = 16'd0;
    logic        BUSY, DONE, ERR, AS, UDS, LDS, RW, DATA_OE;
    logic [15:0] RDATA, DATA_OUT;
    logic [23:0] ADDR_OUT;
    logic [15:0] DATA_IN = 16'd0;
    logic        DTACK = 1'b1;
    logic        BERR = 1'b1;

    bus_master #(.TIMEOUT(64)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_SIZE(REQ_SIZE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .RDATA(RDATA), .ADDR_OUT(ADDR_OUT), .AS(AS), .UDS(UDS),
        .LDS(LDS), .RW(RW), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
        .DATA_IN(DATA_IN), .DTACK(DTACK), .BERR(BERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rw;
        logic        size;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] din;
        int          ack_k;     // AS-low cycle on which the responder answers; 0 = never
        logic        drv_dtack;
        logic        drv_berr;
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_rdata;
        logic        exp_uds;
        logic        exp_lds;
        logic [15:0] exp_dout;
        int          exp_as;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        done;
        logic        err;
        logic [15:0] rdata;
    } sb_t;

    sb_t         sbq[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [23:0] last_addr = 24'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every DONE/ERR pulse is matched against the oldest pending request.
    always @(negedge CLK) begin
        if (!RST && (DONE || ERR)) begin
            chk("done_err_exclusive", {31'd0, DONE & ERR}, 32'd0);
            if (sbq.size() == 0) begin
                chk("sb_unexpected_pulse", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("sb_done", {31'd0, DONE}, {31'd0, e.done});
                chk("sb_err", {31'd0, ERR}, {31'd0, e.err});
                chk("sb_rdata", {16'd0, RDATA}, {16'd0, e.rdata});
            end
        end
    end

    // Called just after a falling edge; issues the request so the next rising edge takes it.
    task automatic run_vec(input vec_t v);
        int          as_cnt;
        logic        fin;
        logic        first_low;
        logic [23:0] exp_addr;
        logic        is_wr;
        exp_addr = v.mis ? last_addr : v.addr;
        is_wr    = !v.rw && !v.mis;
        REQ = 1'b1; REQ_RW = v.rw; REQ_SIZE = v.size; REQ_ADDR = v.addr;
        REQ_WDATA = v.wdata; DATA_IN = v.din;
        sbq.push_back('{v.exp_done, v.exp_err, v.exp_rdata});
        as_cnt = 0; fin = 1'b0; first_low = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            @(negedge CLK);
            if (c == 0) begin
                chk("busy_after_req", {31'd0, BUSY}, 32'd1);
                chk("as_high_first", {31'd0, AS}, 32'd1);
                chk("addr_out", {8'd0, ADDR_OUT}, {8'd0, exp_addr});
                chk("oe_first", {31'd0, DATA_OE}, {31'd0, is_wr});
                if (is_wr) begin
                    chk("dout", {16'd0, DATA_OUT}, {16'd0, v.exp_dout});
                    chk("rw_write", {31'd0, RW}, 32'd0);
                end
                REQ = 1'b0;
                REQ_ADDR = 24'($urandom); REQ_WDATA = 16'($urandom);
                REQ_RW = 1'($urandom); REQ_SIZE = 1'($urandom);
            end
            if (AS == 1'b0) begin
                as_cnt++;
                if (first_low) begin
                    chk("uds", {31'd0, UDS}, {31'd0, v.exp_uds});
                    chk("lds", {31'd0, LDS}, {31'd0, v.exp_lds});
                    chk("rw_strobe", {31'd0, RW}, {31'd0, v.rw});
                    if (is_wr) chk("oe_strobe", {31'd0, DATA_OE}, 32'd1);
                    first_low = 1'b0;
                end
                if (v.ack_k > 0 && as_cnt == v.ack_k) begin
                    DTACK = ~v.drv_dtack;
                    BERR  = ~v.drv_berr;
                end
            end
            if (DONE || ERR) begin
                fin = 1'b1;
                chk("as_high_end", {31'd0, AS}, 32'd1);
                chk("oe_end", {31'd0, DATA_OE}, {31'd0, is_wr});
            end
        end
        if (!fin) chk("end_reached", 32'd0, 32'd1);
        DTACK = 1'b1; BERR = 1'b1;
        chk("as_low_cycles", as_cnt, v.exp_as);
        @(negedge CLK);
        chk("recover_busy", {31'd0, BUSY}, 32'd1);
        chk("recover_rw", {31'd0, RW}, 32'd1);
        chk("recover_oe", {31'd0, DATA_OE}, 32'd0);
        chk("recover_pulse", {30'd0, DONE, ERR}, 32'd0);
        @(negedge CLK);
        chk("idle_busy", {31'd0, BUSY}, 32'd0);
        chk("idle_addr", {8'd0, ADDR_OUT}, {8'd0, exp_addr});
        chk("idle_rdata", {16'd0, RDATA}, {16'd0, v.exp_rdata});
        last_addr = exp_addr;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_as"}, {29'd0, AS, UDS, LDS}, 32'h7);
        chk({tag, "_busy"}, {29'd0, BUSY, DONE, ERR}, 32'd0);
        chk({tag, "_rw_oe"}, {30'd0, RW, DATA_OE}, 32'h2);
        chk({tag, "_addr"}, {8'd0, ADDR_OUT}, 32'd0);
        chk({tag, "_data"}, {DATA_OUT, RDATA}, 32'd0);
    endtask

    vec_t vecs[11];
    vec_t rv;

    initial begin
        //          rw    size  addr         wdata     din       ack dt    be    done  err   rdata     uds   lds   dout      as  mis
        vecs[0]  = '{1'b1, 1'b0, 24'h120034, 16'h0000, 16'hBEEF, 2, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 2,  1'b0};
        vecs[1]  = '{1'b0, 1'b1, 24'h000101, 16'h005A, 16'h0000, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h5A5A, 1,  1'b0};
        vecs[2]  = '{1'b1, 1'b1, 24'h000100, 16'h0000, 16'h12AB, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0012, 1'b0, 1'b1, 16'h0000, 1,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 24'h000101, 16'h0000, 16'h12AB, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00AB, 1'b1, 1'b0, 16'h0000, 1,  1'b0};
        vecs[4]  = '{1'b1, 1'b0, 24'h000200, 16'h0000, 16'hFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0, 16'h0000, 64, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 24'h000400, 16'h0000, 16'h5555, 3, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b0, 16'h0000, 3,  1'b0};
        vecs[6]  = '{1'b1, 1'b0, 24'h000003, 16'h0000, 16'h7777, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00AB, 1'b1, 1'b1, 16'h0000, 0,  1'b1};
        vecs[7]  = '{1'b0, 1'b0, 24'h0A0010, 16'h1234, 16'h0000, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00AB, 1'b0, 1'b0, 16'h1234, 1,  1'b0};
        vecs[8]  = '{1'b0, 1'b1, 24'h000020, 16'hA5C3, 16'h0000, 2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AB, 1'b0, 1'b1, 16'hC3C3, 2,  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 24'h000010, 16'h0000, 16'h8001, 4, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 1'b0, 1'b0, 16'h0000, 4,  1'b0};
        vecs[10] = '{1'b0, 1'b0, 24'h000011, 16'hDEAD, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b1, 16'h0000, 0,  1'b1};

        // Power-on reset state, then a request on the first edge after release.
        repeat (3) @(negedge CLK);
        chk_reset_state("reset");
        #1 RST = 1'b0;
        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // Reset while AS is low: bus released without a clock edge.
        REQ = 1'b1; REQ_RW = 1'b1; REQ_SIZE = 1'b0; REQ_ADDR = 24'h000300;
        @(negedge CLK);
        REQ = 1'b0;
        for (int c = 0; c < 20 && AS; c++) @(negedge CLK);
        chk("midrst_as_low", {31'd0, AS}, 32'd0);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk_reset_state("midrst");
        sbq.delete();
        last_addr = 24'd0;
        @(negedge CLK);
        #1 RST = 1'b0;
        rv = '{1'b1, 1'b0, 24'h000300, 16'h0000, 16'h4242, 1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4242, 1'b0, 1'b0, 16'h0000, 1, 1'b0};
        run_vec(rv);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
